// File: rtl/aespim_sequencer.sv
// Initiator-side sequencer for the AES PIM accelerator command port:
// loads a 128-bit block as 4 LD ops, optionally runs KEX with done-wait, then reads back with 4 ST ops.
module aespim_sequencer #(
  parameter int unsigned NUM_WORDS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [127:0] req_data_i,
  input  logic         req_kex_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output logic [127:0] resp_data_o,
  output logic         resp_err_o,
  output logic         accel_start_o,
  output logic [3:0]   accel_op_o,
  output logic [31:0]  accel_data_o,
  input  logic [31:0]  accel_data_i,
  input  logic         accel_done_i,
  output logic         busy_o
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = NUM_WORDS * WORD_W;
  localparam int unsigned CNT_W   = $clog2(NUM_WORDS);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_KEX = 4'h2;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KEX_START,
    S_KEX_WAIT,
    S_STORE,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [BLOCK_W-1:0]   req_q, req_d;
  logic                 kex_q, kex_d;
  logic                 req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [BLOCK_W-1:0]   resp_data_q, resp_data_d;
  logic                 start_q, start_d;
  logic [3:0]           op_q, op_d;
  logic [WORD_W-1:0]    adata_q, adata_d;

  // Next-state and next-output logic; every output is the registered copy of its _d value
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    req_d        = req_q;
    kex_d        = kex_q;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    start_d      = 1'b0;
    op_d         = OP_NOP;
    adata_d      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          state_d     = S_LOAD;
          req_d       = req_data_i;
          kex_d       = req_kex_i;
          cnt_d       = '0;
          to_d        = '0;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          resp_err_d  = 1'b0;
          resp_data_d = '0;
          op_d        = OP_LD;
          adata_d     = req_data_i[WORD_W-1:0];
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (kex_q) begin
            state_d = S_KEX_START;
            op_d    = OP_KEX;
            start_d = 1'b1;
          end else begin
            state_d = S_STORE;
            op_d    = OP_ST;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          op_d    = OP_LD;
          adata_d = req_q[{cnt_d, 5'd0} +: WORD_W];
        end
      end
      // Start cycle: done is not yet meaningful, so it is not sampled here
      S_KEX_START: begin
        state_d = S_KEX_WAIT;
        to_d    = '0;
      end
      S_KEX_WAIT: begin
        if (accel_done_i) begin
          state_d = S_STORE;
          op_d    = OP_ST;
          cnt_d   = '0;
        end else if (to_q == TO_LAST) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_STORE: begin
        resp_data_d[{cnt_q, 5'd0} +: WORD_W] = accel_data_i;
        if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          op_d  = OP_ST;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      to_q         <= '0;
      req_q        <= '0;
      kex_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      start_q      <= 1'b0;
      op_q         <= OP_NOP;
      adata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      req_q        <= req_d;
      kex_q        <= kex_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      start_q      <= start_d;
      op_q         <= op_d;
      adata_q      <= adata_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign busy_o        = busy_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_err_o    = resp_err_q;
  assign resp_data_o   = resp_data_q;
  assign accel_start_o = start_q;
  assign accel_op_o    = op_q;
  assign accel_data_o  = adata_q;

endmodule

// File: tb/tb_aespim_sequencer.sv
// Directed bench for aespim_sequencer with a small shift-register accelerator model
// (KEX xors every word with a fixed mask so results are easy to hand-compute).
module tb_aespim_sequencer;

  localparam int unsigned TO = 8;
  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_KEX = 4'h2;
  localparam logic [3:0] OP_NOP = 4'hF;
  localparam logic [31:0] KMASK = 32'hA5A5A5A5;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [127:0] req_data_i = '0;
  logic         req_kex_i = 1'b0;
  logic         resp_valid_o;
  logic         resp_ready_i = 1'b0;
  logic [127:0] resp_data_o;
  logic         resp_err_o;
  logic         accel_start_o;
  logic [3:0]   accel_op_o;
  logic [31:0]  accel_data_o;
  logic [31:0]  accel_data_i;
  logic         accel_done_i = 1'b0;
  logic         busy_o;

  int checks = 0;
  int failures = 0;

  aespim_sequencer #(.NUM_WORDS(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i), .req_kex_i(req_kex_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .accel_start_o(accel_start_o), .accel_op_o(accel_op_o),
    .accel_data_o(accel_data_o), .accel_data_i(accel_data_i),
    .accel_done_i(accel_done_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Accelerator model: LD shifts in at the top, ST reads slot 0 and rotates
  logic [31:0] mem [4];
  assign accel_data_i = mem[0];
  always @(posedge clk_i) begin
    case (accel_op_o)
      OP_LD: begin
        mem[0] <= mem[1]; mem[1] <= mem[2]; mem[2] <= mem[3]; mem[3] <= accel_data_o;
      end
      OP_ST: begin
        mem[0] <= mem[1]; mem[1] <= mem[2]; mem[2] <= mem[3]; mem[3] <= mem[0];
      end
      OP_KEX: begin
        for (int i = 0; i < 4; i++) mem[i] <= mem[i] ^ KMASK;
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req_ready"}, req_ready_o, 1'b1);
    check_eq({tag, "_resp_valid"}, resp_valid_o, 1'b0);
    check_eq({tag, "_resp_err"}, resp_err_o, 1'b0);
    check_eq({tag, "_resp_data"}, resp_data_o, 128'h0);
    check_eq({tag, "_start"}, accel_start_o, 1'b0);
    check_eq({tag, "_op"}, accel_op_o, OP_NOP);
    check_eq({tag, "_adata"}, accel_data_o, 32'h0);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
  endtask

  // One full transaction, checked cycle by cycle from the accept cycle T.
  // done_dly: cycles after the KEX start at which done pulses (<0: never).
  task automatic do_txn(input logic [127:0] d, input logic kex, input int done_dly,
                        input int ready_dly, input logic spur);
    logic [127:0] exp_d;
    logic [31:0]  w;
    logic         tmo;
    tmo   = kex && (done_dly < 0);
    exp_d = tmo ? 128'h0 : (kex ? (d ^ {4{KMASK}}) : d);
    if (spur) begin
      accel_done_i = 1'b1;
      step();
      check_eq("idle_spur_op", accel_op_o, OP_NOP);
    end
    check_eq("accept_ready", req_ready_o, 1'b1);
    check_eq("accept_busy", busy_o, 1'b0);
    req_valid_i = 1'b1;
    req_data_i  = d;
    req_kex_i   = kex;
    step();
    req_valid_i = 1'b0;
    req_data_i  = '0;
    req_kex_i   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = d[32*k +: 32];
      accel_done_i = spur;
      check_eq($sformatf("ld%0d_op", k), accel_op_o, OP_LD);
      check_eq($sformatf("ld%0d_data", k), accel_data_o, w);
      check_eq($sformatf("ld%0d_start", k), accel_start_o, 1'b0);
      check_eq($sformatf("ld%0d_busy", k), busy_o, 1'b1);
      check_eq($sformatf("ld%0d_ready", k), req_ready_o, 1'b0);
      step();
    end
    accel_done_i = 1'b0;
    if (kex) begin
      check_eq("kex_op", accel_op_o, OP_KEX);
      check_eq("kex_start", accel_start_o, 1'b1);
      step();
      for (int n = 1; n <= TO; n++) begin
        check_eq($sformatf("wait%0d_op", n), accel_op_o, OP_NOP);
        check_eq($sformatf("wait%0d_start", n), accel_start_o, 1'b0);
        check_eq($sformatf("wait%0d_valid", n), resp_valid_o, 1'b0);
        accel_done_i = (n == done_dly);
        step();
        accel_done_i = 1'b0;
        if (n == done_dly) break;
      end
    end
    if (!tmo) begin
      for (int k = 0; k < 4; k++) begin
        accel_done_i = spur;
        check_eq($sformatf("st%0d_op", k), accel_op_o, OP_ST);
        check_eq($sformatf("st%0d_valid", k), resp_valid_o, 1'b0);
        step();
      end
      accel_done_i = 1'b0;
    end
    for (int r = 0; r < ready_dly; r++) begin
      req_valid_i = 1'b1;
      req_data_i  = ~d;
      check_eq("hold_valid", resp_valid_o, 1'b1);
      check_eq("hold_data", resp_data_o, exp_d);
      check_eq("hold_err", resp_err_o, tmo);
      check_eq("hold_req_ready", req_ready_o, 1'b0);
      check_eq("hold_busy", busy_o, 1'b1);
      step();
    end
    resp_ready_i = 1'b1;
    check_eq("resp_valid", resp_valid_o, 1'b1);
    check_eq("resp_data", resp_data_o, exp_d);
    check_eq("resp_err", resp_err_o, tmo);
    check_eq("resp_op", accel_op_o, OP_NOP);
    check_eq("resp_req_ready", req_ready_o, 1'b0);
    step();
    resp_ready_i = 1'b0;
    req_valid_i  = 1'b0;
    req_data_i   = '0;
    check_eq("post_valid", resp_valid_o, 1'b0);
    check_eq("post_req_ready", req_ready_o, 1'b1);
    check_eq("post_busy", busy_o, 1'b0);
  endtask

  initial begin
    #2 rst_ni = 1'b0;
    #1 check_reset_vals("rst");
    step();
    step();
    rst_ni = 1'b1;
    step();
    check_reset_vals("idle");

    // 1: plain echo
    do_txn(128'h33333333_22222222_11111111_00000000, 1'b0, -1, 0, 1'b0);
    // 2: KEX with done 3 cycles after start
    do_txn(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b1, 3, 0, 1'b0);
    // 3: KEX timeout
    do_txn(128'h0F0F0F0F_F0F0F0F0_12345678_87654321, 1'b1, -1, 0, 1'b0);
    // 4: held response then back-to-back request
    do_txn(128'hAAAA5555_5555AAAA_FFFF0000_0000FFFF, 1'b0, -1, 10, 1'b0);
    do_txn(128'h44444444_55555555_66666666_77777777, 1'b1, 1, 0, 1'b0);

    // 5: reset while word 2 is on the bus
    req_valid_i = 1'b1;
    req_data_i  = 128'h99999999_88888888_77777777_66666666;
    req_kex_i   = 1'b0;
    step();
    req_valid_i = 1'b0;
    step();
    step();
    check_eq("mid_ld2_data", accel_data_o, 32'h88888888);
    rst_ni = 1'b0;
    #1 check_reset_vals("midrst");
    step();
    rst_ni = 1'b1;
    step();
    do_txn(128'h13579BDF_2468ACE0_FEDCBA98_76543210, 1'b0, -1, 0, 1'b0);

    // 6: spurious done in IDLE, LOAD and STORE
    do_txn(128'h33333333_22222222_11111111_00000000, 1'b0, -1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
